// File: rtl/priority_request_scheduler.sv
// priority_request_scheduler
//
// Captures a 16-bit request vector and hands out the index of each set bit, one per accepted
// transfer, in priority order (highest index first, or lowest first when LSB_FIRST=1).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_in[15:0]   request vector, captured on load while load_ready=1
//   load           capture request (ignored unless load_ready=1 and req_in is non-zero)
//   load_ready     high in IDLE
//   flush          synchronous abort, overrides load and transfer
//   idx_out[3:0]   index currently offered (0 when idx_valid=0)
//   idx_valid      idx_out is valid (high in SERVE)
//   idx_ready      consumer accepts idx_out
//   pending_count  set bits remaining in the pending register, 0..16

module priority_request_scheduler #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_in,
  input  logic        load,
  output logic        load_ready,
  input  logic        flush,
  output logic [3:0]  idx_out,
  output logic        idx_valid,
  input  logic        idx_ready,
  output logic [4:0]  pending_count
);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  count_q, count_d;

  logic [3:0]  idx_sel;
  logic [15:0] pending_cleared;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  // Priority encoder: the last match in loop order wins, so the loop direction picks the
  // end of the vector that is served first.
  always_comb begin
    idx_sel = '0;
    if (LSB_FIRST) begin
      for (int i = 15; i >= 0; i--) begin
        if (pending_q[i]) idx_sel = 4'(i);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pending_q[i]) idx_sel = 4'(i);
      end
    end
  end

  assign pending_cleared = pending_q & ~(16'b1 << idx_sel);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    if (flush) begin
      // A transfer on this edge is still seen by the consumer; only our copy is dropped.
      state_d   = StIdle;
      pending_d = '0;
      count_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load && (req_in != 16'h0000)) begin
            state_d   = StServe;
            pending_d = req_in;
            count_d   = popcount16(req_in);
          end
        end
        StServe: begin
          if (idx_ready) begin
            pending_d = pending_cleared;
            count_d   = count_q - 5'd1;
            if (pending_cleared == 16'h0000) state_d = StIdle;
          end
        end
        default: begin
          state_d   = StIdle;
          pending_d = '0;
          count_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign load_ready    = (state_q == StIdle);
  assign idx_valid     = (state_q == StServe);
  assign idx_out       = idx_valid ? idx_sel : 4'd0;
  assign pending_count = count_q;

endmodule

// File: tb/tb_priority_request_scheduler.sv
// Bench for priority_request_scheduler: one instance per service order, a queue-based
// reference model, a vector table for the directed scenarios and a randomized phase.

module tb_priority_request_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_in;
  logic        load;
  logic        flush;
  logic        idx_ready;

  logic        load_ready0, idx_valid0, load_ready1, idx_valid1;
  logic [3:0]  idx_out0, idx_out1;
  logic [4:0]  pending_count0, pending_count1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered list of indices still to be delivered, one per service order.
  int q0[$];
  int q1[$];

  priority_request_scheduler #(.LSB_FIRST(1'b0)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_in        (req_in),
    .load          (load),
    .load_ready    (load_ready0),
    .flush         (flush),
    .idx_out       (idx_out0),
    .idx_valid     (idx_valid0),
    .idx_ready     (idx_ready),
    .pending_count (pending_count0)
  );

  priority_request_scheduler #(.LSB_FIRST(1'b1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_in        (req_in),
    .load          (load),
    .load_ready    (load_ready1),
    .flush         (flush),
    .idx_out       (idx_out1),
    .idx_valid     (idx_valid1),
    .idx_ready     (idx_ready),
    .pending_count (pending_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update for one clock edge, using the inputs that were stable before it.
  task automatic model_edge();
    if (!rst_n || flush) begin
      q0.delete();
      q1.delete();
    end else if (q0.size() == 0) begin
      if (load && req_in != 16'h0000) begin
        for (int i = 15; i >= 0; i--) if (req_in[i]) q0.push_back(i);
        for (int i = 0; i < 16; i++) if (req_in[i]) q1.push_back(i);
      end
    end else if (idx_ready) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
  endtask

  task automatic model_check(input string tag);
    int e0, e1;
    e0 = (q0.size() != 0) ? q0[0] : 0;
    e1 = (q1.size() != 0) ? q1[0] : 0;
    chk({tag, " valid0"}, 32'(idx_valid0), 32'(q0.size() != 0));
    chk({tag, " idx0"},   32'(idx_out0), 32'(e0));
    chk({tag, " count0"}, 32'(pending_count0), 32'(q0.size()));
    chk({tag, " ready0"}, 32'(load_ready0), 32'(q0.size() == 0));
    chk({tag, " valid1"}, 32'(idx_valid1), 32'(q1.size() != 0));
    chk({tag, " idx1"},   32'(idx_out1), 32'(e1));
    chk({tag, " count1"}, 32'(pending_count1), 32'(q1.size()));
    chk({tag, " ready1"}, 32'(load_ready1), 32'(q1.size() == 0));
  endtask

  // One clock: update the model at the edge, then check 2 ns later; inputs change after that.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #2;
    model_check(tag);
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] req;
    logic        fl;
    logic        rdy;
    logic        e_valid;
    logic [3:0]  e_idx;
    logic [4:0]  e_cnt;
    logic        e_lr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Directed vectors, expectations for the highest-first instance after each edge.
    vecs[0]  = '{1'b1, 16'h8001, 1'b0, 1'b1, 1'b1, 4'd15, 5'd2, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd0,  5'd1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0, 1'b1};
    vecs[3]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0, 1'b1};
    vecs[4]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 4'd1,  5'd2, 1'b0};
    vecs[5]  = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd0,  5'd1, 1'b0};
    vecs[6]  = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0, 1'b1};
    vecs[8]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 4'd6,  5'd1, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd6,  5'd1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd6,  5'd1, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd6,  5'd1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd6,  5'd1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0, 1'b1};
    vecs[14] = '{1'b1, 16'h00F0, 1'b0, 1'b1, 1'b1, 4'd7,  5'd4, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd6,  5'd3, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  5'd0, 1'b1};
    vecs[17] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0, 1'b1};

    rst_n     = 1'b0;
    req_in    = '0;
    load      = 1'b0;
    flush     = 1'b0;
    idx_ready = 1'b0;

    #12;
    chk("reset ready0", 32'(load_ready0), 32'd1);
    chk("reset valid0", 32'(idx_valid0), 32'd0);
    chk("reset idx0",   32'(idx_out0), 32'd0);
    chk("reset count0", 32'(pending_count0), 32'd0);
    chk("reset valid1", 32'(idx_valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed scenarios.
    for (int v = 0; v < 18; v++) begin
      load      = vecs[v].ld;
      req_in    = vecs[v].req;
      flush     = vecs[v].fl;
      idx_ready = vecs[v].rdy;
      tick($sformatf("vec%0d", v));
      chk($sformatf("vec%0d tbl valid", v), 32'(idx_valid0), 32'(vecs[v].e_valid));
      chk($sformatf("vec%0d tbl idx", v),   32'(idx_out0), 32'(vecs[v].e_idx));
      chk($sformatf("vec%0d tbl count", v), 32'(pending_count0), 32'(vecs[v].e_cnt));
      chk($sformatf("vec%0d tbl ready", v), 32'(load_ready0), 32'(vecs[v].e_lr));
    end
    load = 1'b0; flush = 1'b0;

    // Full vector drains in exactly 16 cycles, in opposite orders for the two instances.
    load = 1'b1; req_in = 16'hFFFF; idx_ready = 1'b1;
    tick("full load");
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("full idx0 k%0d", k), 32'(idx_out0), 32'(15 - k));
      chk($sformatf("full idx1 k%0d", k), 32'(idx_out1), 32'(k));
      chk($sformatf("full count k%0d", k), 32'(pending_count0), 32'(16 - k));
      tick($sformatf("full k%0d", k));
    end
    chk("full done ready0", 32'(load_ready0), 32'd1);
    chk("full done ready1", 32'(load_ready1), 32'd1);

    // Asynchronous reset in the middle of serving.
    load = 1'b1; req_in = 16'hA5A5; idx_ready = 1'b1;
    tick("pre-reset load");
    tick("pre-reset xfer");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async valid0", 32'(idx_valid0), 32'd0);
    chk("async idx0",   32'(idx_out0), 32'd0);
    chk("async count0", 32'(pending_count0), 32'd0);
    chk("async ready0", 32'(load_ready0), 32'd1);
    chk("async count1", 32'(pending_count1), 32'd0);
    load = 1'b1; req_in = 16'hABCD;
    tick("in reset 0");
    tick("in reset 1");
    rst_n = 1'b1;
    req_in = 16'h0120; idx_ready = 1'b0;
    tick("post-reset load");
    chk("post-reset idx0", 32'(idx_out0), 32'd8);
    chk("post-reset idx1", 32'(idx_out1), 32'd5);
    load = 1'b0; idx_ready = 1'b1;
    tick("post-reset xfer0");
    tick("post-reset xfer1");
    chk("post-reset idle", 32'(load_ready0), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      load = ($urandom_range(0, 2) == 0);
      unique case (sel)
        0: req_in = 16'h0000;
        1: req_in = 16'h1 << $urandom_range(0, 15);
        default: req_in = 16'($urandom());
      endcase
      flush     = ($urandom_range(0, 19) == 0);
      idx_ready = ($urandom_range(0, 3) != 0);
      tick($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
